// File: rtl/spart_pkg.sv
// Shared SPART definitions: register map, transmitter states and default oversampling.
package spart_pkg;

    localparam int unsigned OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] ADDR_TXRX   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } tx_state_e;

endpackage

// File: rtl/spart_bit_timer.sv
// Counts baud enable ticks and flags the tick that closes one serial bit period.
module spart_bit_timer
    import spart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic enable,
    output logic bit_end_c
);

    localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter is held at zero while idle so every frame starts on a fresh bit period.
    always_comb begin
        cnt_d     = cnt_q;
        bit_end_c = run && enable && (cnt_q == CNT_MAX);
        if (!run) begin
            cnt_d = '0;
        end else if (bit_end_c) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: one-byte holding register feeding an 8N1 serializer.
module spart_tx
    import spart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] data_bus,
    output logic       txd,
    output logic       tbr,
    output logic       busy
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txd_q, txd_d;
    logic       tbr_q, tbr_d;
    logic       busy_q, busy_d;
    logic       wr_c;
    logic       bit_end_c;
    logic       timer_run_c;

    assign timer_run_c = (state_q != IDLE);

    spart_bit_timer #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (timer_run_c),
        .enable   (enable),
        .bit_end_c(bit_end_c)
    );

    assign wr_c = iocs && !iorw && (ioaddr == ADDR_TXRX) && tbr_q;

    // A write can only land while holding is empty, so it never collides with a load.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_idx_d   = bit_idx_q;
        txd_d       = txd_q;

        if (wr_c) begin
            hold_d      = data_bus;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_d      = '0;
                    hold_full_d = 1'b0;
                    bit_idx_d   = '0;
                    state_d     = START;
                    txd_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end_c) begin
                    state_d = DATA;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                // Chain straight into the next start bit when a byte is waiting.
                if (bit_end_c) begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_d      = '0;
                        hold_full_d = 1'b0;
                        bit_idx_d   = '0;
                        state_d     = START;
                        txd_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase

        tbr_d  = !hold_full_d;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            txd_q       <= 1'b1;
            tbr_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_idx_q   <= bit_idx_d;
            txd_q       <= txd_d;
            tbr_q       <= tbr_d;
            busy_q      <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign tbr  = tbr_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_spart_tx.sv
// Bench for spart_tx: a line decoder checks transmitted bytes against a queue of expected writes.
module tb_spart_tx;

    localparam int unsigned OS = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data_bus;
    logic       txd;
    logic       tbr;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    int en_mode = 0;
    int cur_run = 0;
    int last_run = 0;
    int runs_done = 0;

    spart_tx #(.OVERSAMPLE(OS)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .iocs    (iocs),
        .iorw    (iorw),
        .ioaddr  (ioaddr),
        .data_bus(data_bus),
        .txd     (txd),
        .tbr     (tbr),
        .busy    (busy)
    );

    initial forever #5 clk = ~clk;

    // Baud tick source: 0 = every cycle, 1 = every 4th cycle, 2 = held low.
    initial begin
        int ph;
        ph = 0;
        enable = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (en_mode)
                0: enable = 1'b1;
                1: begin
                    enable = (ph == 0);
                    ph = (ph + 1) % 4;
                end
                default: enable = 1'b0;
            endcase
        end
    end

    // Line monitor: tracks busy runs and decodes frames mid-bit by counting enable ticks.
    initial begin
        int mcnt;
        int b;
        bit active;
        logic [9:0] fb;
        logic [7:0] exp;
        mcnt = 0;
        active = 1'b0;
        fb = '0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cur_run++;
            end else if (cur_run > 0) begin
                last_run = cur_run;
                cur_run = 0;
                runs_done++;
            end
            if (rst !== 1'b0) begin
                active = 1'b0;
                mcnt = 0;
            end else begin
                if (!active && txd === 1'b0) begin
                    active = 1'b1;
                    mcnt = 0;
                end
                if (active && enable === 1'b1) begin
                    if (mcnt % OS == OS / 2) begin
                        b = mcnt / OS;
                        fb[b] = txd;
                        if (b == 9) begin
                            active = 1'b0;
                            checks++;
                            if (exp_q.size() == 0) begin
                                errors++;
                                $display("FAIL frame_unexpected: got frame bits %b, expected no frame", fb);
                            end else begin
                                exp = exp_q.pop_front();
                                if (fb[0] !== 1'b0 || fb[9] !== 1'b1 || fb[8:1] !== exp) begin
                                    errors++;
                                    $display("FAIL frame_data: got start=%b data=0x%02h stop=%b, expected start=0 data=0x%02h stop=1",
                                             fb[0], fb[8:1], fb[9], exp);
                                end
                            end
                        end
                    end
                    mcnt++;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_set(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] d);
        iocs = cs;
        iorw = rw;
        ioaddr = a;
        data_bus = d;
    endtask

    task automatic bus_idle();
        iocs = 1'b0;
        iorw = 1'b1;
        ioaddr = 2'b00;
        data_bus = 8'h00;
    endtask

    // Drives one TX-data write cycle; returns early in the following cycle.
    task automatic write_tx(input logic [7:0] d);
        step();
        bus_set(1'b1, 1'b0, 2'b00, d);
        step();
        bus_idle();
    endtask

    task automatic wait_run_done(input string name, output int run);
        int start;
        int n;
        start = runs_done;
        n = 0;
        while (runs_done == start && n < 5000) begin
            @(negedge clk);
            n++;
        end
        run = last_run;
        if (runs_done == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still high after %0d cycles, expected it to fall", name, n);
            run = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_idle();
        en_mode = 0;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, expected 1", txd); end
        checks++;
        if (tbr !== 1'b1) begin errors++; $display("FAIL reset_tbr: got %b, expected 1", tbr); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        step();
        rst = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_frame();
        int run;
        exp_q.push_back(8'h55);
        write_tx(8'h55);
        @(negedge clk);
        checks++;
        if (tbr !== 1'b0) begin errors++; $display("FAIL lat_n1_tbr: got %b, expected 0", tbr); end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0 || busy !== 1'b1 || tbr !== 1'b1) begin
            errors++;
            $display("FAIL lat_n2: got txd=%b busy=%b tbr=%b, expected txd=0 busy=1 tbr=1", txd, busy, tbr);
        end
        wait_run_done("single", run);
        checks++;
        if (run != 10 * OS) begin errors++; $display("FAIL single_busy_len: got %0d, expected %0d", run, 10 * OS); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_pending: got %0d, expected 0", exp_q.size()); end
        repeat (5) step();
    endtask

    task automatic test_back_to_back();
        int run;
        int n;
        exp_q.push_back(8'hA5);
        write_tx(8'hA5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tbr !== 1'b1 && n < 20);
        checks++;
        if (tbr !== 1'b1) begin errors++; $display("FAIL b2b_tbr_return: got %b, expected 1", tbr); end
        exp_q.push_back(8'h3C);
        write_tx(8'h3C);
        wait_run_done("b2b", run);
        checks++;
        if (run != 20 * OS) begin errors++; $display("FAIL b2b_busy_len: got %0d, expected %0d", run, 20 * OS); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d, expected 0", exp_q.size()); end
        repeat (5) step();
    endtask

    task automatic test_drop_when_full();
        int run;
        int bad;
        exp_q.push_back(8'h11);
        step();
        bus_set(1'b1, 1'b0, 2'b00, 8'h11);
        step();
        bus_set(1'b1, 1'b0, 2'b00, 8'h22);
        @(negedge clk);
        checks++;
        if (tbr !== 1'b0) begin errors++; $display("FAIL drop_tbr: got %b, expected 0", tbr); end
        step();
        bus_idle();
        wait_run_done("drop", run);
        checks++;
        if (run != 10 * OS) begin errors++; $display("FAIL drop_busy_len: got %0d, expected %0d", run, 10 * OS); end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL drop_quiet: got %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_slow_enable();
        int n;
        int bad;
        en_mode = 1;
        exp_q.push_back(8'hF0);
        write_tx(8'hF0);
        n = 0;
        while (txd !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (280) @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL slow_bit3: got %b, expected 0", txd); end
        en_mode = 2;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL slow_freeze: got %0d changed cycles, expected 0", bad); end
        en_mode = 1;
        n = 0;
        while (txd !== 1'b1 && n < 200) begin @(negedge clk); n++; end
        n = 0;
        while (busy === 1'b1 && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (n != 5 * 4 * OS) begin errors++; $display("FAIL slow_tail_len: got %0d, expected %0d", n, 5 * 4 * OS); end
        en_mode = 0;
        repeat (5) step();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL slow_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int bad;
        exp_q.push_back(8'h81);
        write_tx(8'h81);
        n = 0;
        while (txd !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (104) @(negedge clk);
        write_tx(8'h99);
        @(negedge clk);
        checks++;
        if (tbr !== 1'b0) begin errors++; $display("FAIL rstmid_hold_full: got tbr=%b, expected 0", tbr); end
        step();
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tbr !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got txd=%b tbr=%b busy=%b, expected 1 1 0", txd, tbr, busy);
        end
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1 || tbr !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_reset_priority();
        int bad;
        step();
        rst = 1'b1;
        bus_set(1'b1, 1'b0, 2'b00, 8'h77);
        step();
        rst = 1'b0;
        bus_idle();
        @(negedge clk);
        checks++;
        if (txd !== 1'b1 || tbr !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstprio_state: got txd=%b tbr=%b busy=%b, expected 1 1 0", txd, tbr, busy);
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || tbr !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstprio_quiet: got %0d active cycles, expected 0", bad); end
    endtask

    task automatic test_ignored_access();
        int bad;
        for (int i = 0; i < 3; i++) begin
            step();
            case (i)
                0: bus_set(1'b1, 1'b0, 2'b10, 8'hFF);
                1: bus_set(1'b1, 1'b1, 2'b00, 8'hFF);
                default: bus_set(1'b0, 1'b0, 2'b00, 8'hFF);
            endcase
            step();
            bus_idle();
            @(negedge clk);
            checks++;
            if (tbr !== 1'b1 || txd !== 1'b1) begin
                errors++;
                $display("FAIL ignored_%0d: got tbr=%b txd=%b, expected 1 1", i, tbr, txd);
            end
        end
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (busy !== 1'b0 || txd !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ignored_quiet: got %0d active cycles, expected 0", bad); end
    endtask

    initial begin
        rst = 1'b1;
        bus_idle();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_drop_when_full();
        test_slow_enable();
        test_reset_mid_frame();
        test_reset_priority();
        test_ignored_access();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL final_pending: got %0d, expected 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
